// File: rtl/alu_arbiter.sv
// Round-robin two-client arbiter and sequencer in front of the shared combinational ALU.
// Optional feature: define ALU_ARB_ILLEGAL_CHK_EN to trap illegal ALU control codes.
module alu_arbiter #(
  parameter int D_WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req0_valid_i,
  output logic               req0_ready_o,
  input  logic [D_WIDTH-1:0] req0_op1_i,
  input  logic [D_WIDTH-1:0] req0_op2_i,
  input  logic [3:0]         req0_ctrl_i,
  input  logic               req1_valid_i,
  output logic               req1_ready_o,
  input  logic [D_WIDTH-1:0] req1_op1_i,
  input  logic [D_WIDTH-1:0] req1_op2_i,
  input  logic [3:0]         req1_ctrl_i,
  output logic [D_WIDTH-1:0] alu_oprnd1_o,
  output logic [D_WIDTH-1:0] alu_oprnd2_o,
  output logic [3:0]         alu_ctrl_o,
  input  logic [D_WIDTH-1:0] alu_result_i,
  input  logic               alu_zero_i,
  input  logic               alu_neg_i,
  output logic               rsp0_valid_o,
  input  logic               rsp0_ready_i,
  output logic [D_WIDTH-1:0] rsp0_result_o,
  output logic               rsp0_zero_o,
  output logic               rsp0_neg_o,
  output logic               rsp0_err_o,
  output logic               rsp1_valid_o,
  input  logic               rsp1_ready_i,
  output logic [D_WIDTH-1:0] rsp1_result_o,
  output logic               rsp1_zero_o,
  output logic               rsp1_neg_o,
  output logic               rsp1_err_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  state_e               state_r;
  state_e               state_s;
  logic                 grant0_s;
  logic                 grant1_s;
  logic                 accept_s;
  logic                 owner_rsp_ready_s;
  logic                 illegal_s;
  logic [D_WIDTH-1:0]   acc_op1_s;
  logic [D_WIDTH-1:0]   acc_op2_s;
  logic [3:0]           acc_ctrl_s;

  logic [D_WIDTH-1:0]   op1_r;
  logic [D_WIDTH-1:0]   op2_r;
  logic [3:0]           ctrl_r;
  logic                 owner_r;
  logic                 last_grant_r;
  logic                 illegal_r;

  logic [1:0]               rsp_valid_r;
  logic [1:0][D_WIDTH-1:0]  rsp_result_r;
  logic [1:0]               rsp_zero_r;
  logic [1:0]               rsp_neg_r;
  logic [1:0]               rsp_err_r;
  logic [D_WIDTH-1:0]       cap_result_s;
  logic                     cap_zero_s;
  logic                     cap_neg_s;

`ifdef ALU_ARB_ILLEGAL_CHK_EN
  function automatic logic ctrl_legal(input logic [3:0] ctrl);
    case (ctrl)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0110,
      4'b1000, 4'b1010, 4'b1011, 4'b1100, 4'b1110: ctrl_legal = 1'b1;
      default:                                     ctrl_legal = 1'b0;
    endcase
  endfunction

  assign illegal_s = ~ctrl_legal(acc_ctrl_s);
`else
  assign illegal_s = 1'b0;
`endif

  // Operands of whichever client wins this cycle.
  always_comb begin
    acc_op1_s  = req0_op1_i;
    acc_op2_s  = req0_op2_i;
    acc_ctrl_s = req0_ctrl_i;
    if (grant1_s) begin
      acc_op1_s  = req1_op1_i;
      acc_op2_s  = req1_op2_i;
      acc_ctrl_s = req1_ctrl_i;
    end else begin
      acc_op1_s  = req0_op1_i;
      acc_op2_s  = req0_op2_i;
      acc_ctrl_s = req0_ctrl_i;
    end
  end

  assign owner_rsp_ready_s = owner_r ? rsp1_ready_i : rsp0_ready_i;
  assign accept_s          = grant0_s | grant1_s;

  // Arbitration and next-state logic; ties go to the client not granted last.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    state_s  = state_r;
    case (state_r)
      IDLE: begin
        if (req0_valid_i && (!req1_valid_i || last_grant_r)) begin
          grant0_s = 1'b1;
        end else begin
          grant0_s = 1'b0;
        end
        if (req1_valid_i && (!req0_valid_i || !last_grant_r)) begin
          grant1_s = 1'b1;
        end else begin
          grant1_s = 1'b0;
        end
        if (grant0_s || grant1_s) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: state_s = RESP;
      RESP: begin
        if (owner_rsp_ready_s) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand, owner and round-robin history captured on the accept edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op1_r        <= {D_WIDTH{1'b0}};
      op2_r        <= {D_WIDTH{1'b0}};
      ctrl_r       <= 4'b0000;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      illegal_r    <= 1'b0;
    end else if (accept_s) begin
      op1_r        <= acc_op1_s;
      op2_r        <= acc_op2_s;
      ctrl_r       <= illegal_s ? 4'b0000 : acc_ctrl_s;
      owner_r      <= grant1_s;
      last_grant_r <= grant1_s;
      illegal_r    <= illegal_s;
    end
  end

  // A trapped illegal op reports a fixed zero result regardless of the ALU.
  always_comb begin
    cap_result_s = alu_result_i;
    cap_zero_s   = alu_zero_i;
    cap_neg_s    = alu_neg_i;
    if (illegal_r) begin
      cap_result_s = {D_WIDTH{1'b0}};
      cap_zero_s   = 1'b1;
      cap_neg_s    = 1'b0;
    end else begin
      cap_result_s = alu_result_i;
      cap_zero_s   = alu_zero_i;
      cap_neg_s    = alu_neg_i;
    end
  end

  // Per-client response registers; only the owner's slot is ever written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_r  <= 2'b00;
      rsp_result_r <= {(2*D_WIDTH){1'b0}};
      rsp_zero_r   <= 2'b00;
      rsp_neg_r    <= 2'b00;
      rsp_err_r    <= 2'b00;
    end else if (state_r == EXEC) begin
      rsp_valid_r[owner_r]  <= 1'b1;
      rsp_result_r[owner_r] <= cap_result_s;
      rsp_zero_r[owner_r]   <= cap_zero_s;
      rsp_neg_r[owner_r]    <= cap_neg_s;
      rsp_err_r[owner_r]    <= illegal_r;
    end else if ((state_r == RESP) && owner_rsp_ready_s) begin
      rsp_valid_r[owner_r]  <= 1'b0;
    end
  end

  assign req0_ready_o  = grant0_s;
  assign req1_ready_o  = grant1_s;
  assign busy_o        = (state_r != IDLE);

  assign alu_oprnd1_o  = op1_r;
  assign alu_oprnd2_o  = op2_r;
  assign alu_ctrl_o    = ctrl_r;

  assign rsp0_valid_o  = rsp_valid_r[0];
  assign rsp0_result_o = rsp_result_r[0];
  assign rsp0_zero_o   = rsp_zero_r[0];
  assign rsp0_neg_o    = rsp_neg_r[0];
  assign rsp1_valid_o  = rsp_valid_r[1];
  assign rsp1_result_o = rsp_result_r[1];
  assign rsp1_zero_o   = rsp_zero_r[1];
  assign rsp1_neg_o    = rsp_neg_r[1];

`ifdef ALU_ARB_ILLEGAL_CHK_EN
  assign rsp0_err_o    = rsp_err_r[0];
  assign rsp1_err_o    = rsp_err_r[1];
`else
  assign rsp0_err_o    = 1'b0;
  assign rsp1_err_o    = 1'b0;
`endif

endmodule
